smmha_tcdm_arbiter: RTL and testbench
=====================================

Name: smmha_tcdm_arbiter

Overview:
Round-robin arbiter that shares one TCDM master port between N_REQ streamer-side requesters, for example the A-load and D-store channels of the smmha streamer. Every granted transaction's requester index is queued so each response is routed back to the requester that issued it. One instance sits per physical TCDM port, between the streamer source/sink modules and the tcdm[MP-1:0] ports of the accelerator top.

Parameters:
N_REQ, 2, number of requester channels (2..8)
ADDR_WIDTH, 32, TCDM address width
DATA_WIDTH, 32, TCDM data width; byte-enable width is DATA_WIDTH/8
MAX_OUTSTANDING, 4, depth of the response-ID FIFO (power of two, >=2)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock, reset is synchronous and active-low
clear_i  in  1  synchronous soft clear from the HWPE controller
in_req_i  in  N_REQ  per-requester request
in_gnt_o  out  N_REQ  per-requester grant
in_add_i  in  N_REQ*ADDR_WIDTH  per-requester address
in_wen_i  in  N_REQ  per-requester write-enable, active-low (1 = read)
in_be_i  in  N_REQ*DATA_WIDTH/8  per-requester byte enables
in_data_i  in  N_REQ*DATA_WIDTH  per-requester write data
in_r_data_o  out  DATA_WIDTH  response data, broadcast to all requesters
in_r_valid_o  out  N_REQ  per-requester response valid
tcdm_req_o  out  1  TCDM request
tcdm_gnt_i  in  1  TCDM grant
tcdm_add_o  out  ADDR_WIDTH  TCDM address
tcdm_wen_o  out  1  TCDM write-enable, active-low
tcdm_be_o  out  DATA_WIDTH/8  TCDM byte enables
tcdm_data_o  out  DATA_WIDTH  TCDM write data
tcdm_r_data_i  in  DATA_WIDTH  TCDM response data
tcdm_r_valid_i  in  1  TCDM response valid; asserted for both reads and writes
busy_o  out  1  one or more transactions outstanding
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  outstanding transaction count
err_o  out  1  sticky error: response arrived with no transaction outstanding

Behaviour:
- Reset (rst_ni=0 at a clk_i edge) and clear_i=1 have the same effect:
  - priority pointer = 0, FIFO emptied, count = 0, err_o = 0
  - outputs therefore read busy_o=0, outstanding_o=0, err_o=0
  - tcdm_req_o, in_gnt_o and in_r_valid_o are combinational and follow from the cleared state.
- Reset or clear mid-transaction discards all outstanding IDs; responses that arrive afterwards are treated as spurious (see below).
- Arbitration (combinational):
  - Winner w = first i with in_req_i[i]=1, scanning ptr, ptr+1, ... modulo N_REQ.
  - tcdm_req_o = (|in_req_i) & ~full.
  - tcdm_add_o, tcdm_wen_o, tcdm_be_o and tcdm_data_o are muxed from w. They are 0 when no request is forwarded.
  - in_gnt_o[w] = tcdm_gnt_i & tcdm_req_o; all other grant bits are 0.
  - Zero-cycle request path.
- Pointer update: on a handshake (tcdm_req_o & tcdm_gnt_i), ptr <= (w+1) mod N_REQ. Otherwise ptr holds; there is no rotation while stalled, so the winner is stable.
- The winner may change between cycles while tcdm_gnt_i=0. Requesters hold their request until granted, per the TCDM protocol.
- Response-ID FIFO:
  - Push w on a handshake; pop on tcdm_r_valid_i.
  - in_r_valid_o[head] = tcdm_r_valid_i & ~empty.
  - in_r_data_o = tcdm_r_data_i, zero-cycle.
  - Responses return in order, one per handshake.
- Full: when count == MAX_OUTSTANDING, tcdm_req_o=0 and all in_gnt_o are 0. This holds even if a pop happens in the same cycle; issue resumes on the next cycle.
- Simultaneous push and pop (not full): count is unchanged, head advances, tail advances.
- Empty with tcdm_r_valid_i=1: the response is dropped, all in_r_valid_o are 0, and err_o <= 1. err_o stays set until reset or clear_i.
- busy_o = (count != 0); outstanding_o = count. Both are registered-state outputs.

Optional Feature:
SMMHA_ARB_STATS_EN
- Defined:
  - Adds output stat_gnt_cnt_o, N_REQ*32 bits: one 32-bit counter per requester.
  - Counter i increments on each handshake granted to requester i and saturates at 0xFFFFFFFF.
  - Counters clear on reset and on clear_i.
  - Adds output stat_stall_cnt_o, 32 bits: counts cycles with (|in_req_i) & ~(tcdm_req_o & tcdm_gnt_i). It saturates and clears the same way.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Fairness: N_REQ=2, both requesters hold req for 8 cycles, tcdm_gnt_i=1, responses return 1 cycle later -> grants alternate 0,1,0,1,...; each requester gets 4 grants; each r_valid is routed to the issuer in order.
- Stall: requester 1 alone, tcdm_gnt_i=0 for 3 cycles then 1 -> tcdm_req_o=1 throughout; in_gnt_o=2'b10 only in cycle 4; ptr becomes 0; outstanding_o becomes 1.
- Full: MAX_OUTSTANDING=4, no responses, continuous requests -> exactly 4 grants, then tcdm_req_o=0; one r_valid -> outstanding_o=3 and a new grant on the next cycle.
- Spurious response: after reset, pulse tcdm_r_valid_i with data 0xDEADBEEF -> all in_r_valid_o=0 and err_o=1 from the next cycle; clear_i=1 -> err_o=0.
- Mid-operation clear: 3 outstanding, assert clear_i -> busy_o=0, outstanding_o=0, ptr=0; later responses set err_o.
- Stats (with SMMHA_ARB_STATS_EN): fairness scenario -> stat_gnt_cnt_o = {4,4}; stall scenario -> stat_stall_cnt_o = 3.

Source files
------------

// File: rtl/smmha_tcdm_arbiter.sv
// Round-robin arbiter that shares one TCDM master port among N_REQ requesters and routes responses back in order.
// Optional per-requester grant and stall counters are enabled with `define SMMHA_ARB_STATS_EN.
module smmha_tcdm_arbiter #(
  parameter int unsigned N_REQ           = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    clear_i,
  input  logic [N_REQ-1:0]                        in_req_i,
  output logic [N_REQ-1:0]                        in_gnt_o,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]        in_add_i,
  input  logic [N_REQ-1:0]                        in_wen_i,
  input  logic [N_REQ-1:0][DATA_WIDTH/8-1:0]      in_be_i,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]        in_data_i,
  output logic [DATA_WIDTH-1:0]                   in_r_data_o,
  output logic [N_REQ-1:0]                        in_r_valid_o,
  output logic                                    tcdm_req_o,
  input  logic                                    tcdm_gnt_i,
  output logic [ADDR_WIDTH-1:0]                   tcdm_add_o,
  output logic                                    tcdm_wen_o,
  output logic [DATA_WIDTH/8-1:0]                 tcdm_be_o,
  output logic [DATA_WIDTH-1:0]                   tcdm_data_o,
  input  logic [DATA_WIDTH-1:0]                   tcdm_r_data_i,
  input  logic                                    tcdm_r_valid_i,
  output logic                                    busy_o,
  output logic [$clog2(MAX_OUTSTANDING):0]        outstanding_o,
  output logic                                    err_o
`ifdef SMMHA_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][31:0]                  stat_gnt_cnt_o,
  output logic [31:0]                             stat_stall_cnt_o
`endif
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [MAX_OUTSTANDING-1:0][IDX_W-1:0] id_q;

  logic [IDX_W-1:0] win;
  logic             full, empty, hs, pop;

  // First requester at or after ptr, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    int unsigned j;
    rr_pick = ptr;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      j = 32'(ptr) + k - 1;
      if (j >= N_REQ) j = j - N_REQ;
      if (req[j]) rr_pick = IDX_W'(j);
    end
  endfunction

  assign win   = rr_pick(in_req_i, ptr_q);
  assign full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign empty = (cnt_q == '0);

  assign tcdm_req_o = (|in_req_i) & ~full;
  assign hs         = tcdm_req_o & tcdm_gnt_i;
  assign pop        = tcdm_r_valid_i & ~empty;

  always_comb begin
    tcdm_add_o  = '0;
    tcdm_wen_o  = 1'b0;
    tcdm_be_o   = '0;
    tcdm_data_o = '0;
    in_gnt_o    = '0;
    if (tcdm_req_o) begin
      tcdm_add_o  = in_add_i[win];
      tcdm_wen_o  = in_wen_i[win];
      tcdm_be_o   = in_be_i[win];
      tcdm_data_o = in_data_i[win];
    end
    if (hs) in_gnt_o[win] = 1'b1;
  end

  always_comb begin
    in_r_valid_o = '0;
    if (pop) in_r_valid_o[id_q[head_q]] = 1'b1;
  end
  assign in_r_data_o = tcdm_r_data_i;

  // Pointer only moves on a handshake so a stalled winner stays put.
  always_comb begin
    ptr_d  = ptr_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    err_d  = err_q | (tcdm_r_valid_i & empty);
    if (hs) begin
      ptr_d  = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
      tail_d = tail_q + 1'b1;
    end
    if (pop) head_d = head_q + 1'b1;
    case ({hs, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      ptr_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (hs) id_q[tail_q] <= win;
  end

  assign busy_o        = (cnt_q != '0);
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

`ifdef SMMHA_ARB_STATS_EN
  logic [N_REQ-1:0][31:0] gnt_cnt_q;
  logic [31:0]            stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      gnt_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_REQ); i++)
        if (in_gnt_o[i] && gnt_cnt_q[i] != '1) gnt_cnt_q[i] <= gnt_cnt_q[i] + 32'd1;
      if ((|in_req_i) && !hs && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stat_gnt_cnt_o   = gnt_cnt_q;
  assign stat_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_smmha_tcdm_arbiter.sv
// Randomized bench for smmha_tcdm_arbiter with an in-bench queue model of the arbiter and response routing.
// Stat counters are also modelled when SMMHA_ARB_STATS_EN is defined.
module tb_smmha_tcdm_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst_n, clear;
  logic [N-1:0]            in_req, in_gnt, in_wen, in_rv;
  logic [N-1:0][AW-1:0]    in_add;
  logic [N-1:0][DW/8-1:0]  in_be;
  logic [N-1:0][DW-1:0]    in_data;
  logic [DW-1:0]           in_rdata, r_data, t_data;
  logic                    t_req, gnt, t_wen, r_valid, busy, err;
  logic [AW-1:0]           t_add;
  logic [DW/8-1:0]         t_be;
  logic [$clog2(MO):0]     outst;
`ifdef SMMHA_ARB_STATS_EN
  logic [N-1:0][31:0]      st_gnt;
  logic [31:0]             st_stall;
`endif

  smmha_tcdm_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .in_req_i(in_req), .in_gnt_o(in_gnt), .in_add_i(in_add), .in_wen_i(in_wen),
    .in_be_i(in_be), .in_data_i(in_data), .in_r_data_o(in_rdata), .in_r_valid_o(in_rv),
    .tcdm_req_o(t_req), .tcdm_gnt_i(gnt), .tcdm_add_o(t_add), .tcdm_wen_o(t_wen),
    .tcdm_be_o(t_be), .tcdm_data_o(t_data), .tcdm_r_data_i(r_data), .tcdm_r_valid_i(r_valid),
    .busy_o(busy), .outstanding_o(outst), .err_o(err)
`ifdef SMMHA_ARB_STATS_EN
    , .stat_gnt_cnt_o(st_gnt), .stat_stall_cnt_o(st_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: issuer IDs in flight, round-robin start, sticky error.
  int  sb[$];
  int  m_ptr = 0;
  bit  m_err = 0;
  bit  started = 0;
  int  m_gnt[N];
  int  m_stall = 0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    bit e_req, hs;
    logic [N-1:0] e_gnt, e_rv;
    w     = pick(in_req, m_ptr);
    e_req = (w >= 0) && (sb.size() < MO);
    hs    = e_req && gnt;
    e_gnt = '0;
    e_rv  = '0;
    if (hs) e_gnt[w] = 1'b1;
    if (r_valid && sb.size() > 0) e_rv[sb[0]] = 1'b1;
    if (started) begin
      chk("tcdm_req", 64'(t_req), 64'(e_req));
      chk("tcdm_add", 64'(t_add), e_req ? 64'(in_add[w]) : 64'd0);
      chk("tcdm_wen", 64'(t_wen), e_req ? 64'(in_wen[w]) : 64'd0);
      chk("tcdm_be", 64'(t_be), e_req ? 64'(in_be[w]) : 64'd0);
      chk("tcdm_data", 64'(t_data), e_req ? 64'(in_data[w]) : 64'd0);
      chk("in_gnt", 64'(in_gnt), 64'(e_gnt));
      chk("in_r_valid", 64'(in_rv), 64'(e_rv));
      chk("in_r_data", 64'(in_rdata), 64'(r_data));
      chk("busy", 64'(busy), 64'(sb.size() != 0));
      chk("outstanding", 64'(outst), 64'(sb.size()));
      chk("err", 64'(err), 64'(m_err));
`ifdef SMMHA_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk($sformatf("stat_gnt%0d", i), 64'(st_gnt[i]), 64'(m_gnt[i]));
      chk("stat_stall", 64'(st_stall), 64'(m_stall));
`endif
    end
    if (!rst_n || clear) begin
      sb.delete();
      m_ptr = 0;
      m_err = 0;
      m_stall = 0;
      for (int i = 0; i < N; i++) m_gnt[i] = 0;
      if (!rst_n) started = 1;
    end else begin
      if (r_valid) begin
        if (sb.size() > 0) void'(sb.pop_front());
        else m_err = 1;
      end
      if (hs) begin
        sb.push_back(w);
        m_ptr = (w + 1) % N;
        m_gnt[w]++;
      end
      if (w >= 0 && !hs) m_stall++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      in_add[i]  = $urandom;
      in_wen[i]  = 1'($urandom_range(0, 1));
      in_be[i]   = (DW/8)'($urandom);
      in_data[i] = $urandom;
    end
    r_data = $urandom;
  endtask

  initial begin
    rst_n = 0; clear = 0; in_req = '0; gnt = 0; r_valid = 0;
    in_add = '0; in_wen = '0; in_be = '0; in_data = '0; r_data = '0;
    repeat (2) step();
    rst_n = 1;
    // Spurious response after reset, then soft clear
    r_valid = 1; r_data = 32'hDEADBEEF; step();
    r_valid = 0; step(); step();
    clear = 1; step();
    clear = 0;
    // All requesters busy, one-cycle response return
    for (int k = 0; k < 12; k++) begin
      rand_payload();
      in_req = '1; gnt = 1; r_valid = (k > 0);
      step();
    end
    in_req = '0; r_valid = 1; step();
    r_valid = 0; step();
    // Stall: single requester, grant withheld for 3 cycles
    in_req = 3'b010; gnt = 0;
    repeat (3) begin rand_payload(); step(); end
    gnt = 1; step();
    in_req = '0; r_valid = 1; step();
    r_valid = 0;
    // Fill to the outstanding limit, then release one slot
    in_req = '1; gnt = 1;
    repeat (6) begin rand_payload(); step(); end
    r_valid = 1; step();
    r_valid = 0; repeat (2) step();
    // Clear with transactions in flight; late responses are spurious
    clear = 1; step();
    clear = 0; in_req = '0; r_valid = 1; repeat (2) step();
    r_valid = 0; clear = 1; step();
    clear = 0;
    // Randomized traffic with shifting response density
    for (int c = 0; c < 3000; c++) begin
      int dens;
      dens = (c / 500) % 3;
      rand_payload();
      in_req  = N'($urandom);
      gnt     = ($urandom_range(0, 3) != 0);
      r_valid = (outst != 0) ? ($urandom_range(0, dens + 1) == 0) : ($urandom_range(0, 63) == 0);
      clear   = ($urandom_range(0, 99) == 0);
      rst_n   = ($urandom_range(0, 499) != 0);
      step();
    end
    clear = 0; rst_n = 1; in_req = '0; r_valid = 0; step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
